// File: rtl/cc1200_spi_sched.sv
// cc1200_spi_sched: round-robin single-register SPI scheduler for four CC1200s.
// Define CC1200_RDY_WAIT_EN to wait for CHIP_RDYn (with timeout) before shifting.
module cc1200_spi_sched #(
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 4,
  parameter int RDY_TIMEOUT = 1024
) (
  input  logic        sysclk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [31:0] hdr,
  input  logic [31:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [7:0]  rdata,
  output logic [7:0]  status,
  output logic        err,
  output logic [3:0]  SCLK,
  output logic [3:0]  CS_n,
  output logic [3:0]  MOSI,
  input  logic [3:0]  MISO
);

  typedef enum logic [2:0] {
    IDLE,
    CS_WAIT,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int CW =
    $clog2(CS_SETUP + RDY_TIMEOUT + CS_HOLD + CLK_DIV + 2);

  state_t      state_q;
  state_t      state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]  ptr_q;
  logic [1:0]  ch_q;
  logic [1:0]  pick;
  logic        found;
  logic        run_q;
  logic [15:0] tx_q;
  logic [15:0] rx_q;
  logic [3:0]  bit_q;
  logic        sclk_q;
  logic [3:0]  done_q;
  logic [7:0]  rdata_q;
  logic [7:0]  status_q;
  logic        err_q;
  logic        miso_s;
  logic        div_end;
  logic        start;
  logic        hold_end;
  logic        tmo;

  assign miso_s  = MISO[ch_q];
  assign div_end = (cnt_q == CW'(CLK_DIV - 1));

  // Round-robin pick: first requester at or after ptr.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and transaction control strobes.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    hold_end = 1'b0;
    tmo      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_q && found) begin
          start   = 1'b1;
          state_d = CS_WAIT;
        end
      end
      CS_WAIT: begin
`ifdef CC1200_RDY_WAIT_EN
        if (cnt_q != '0 && !miso_s) begin
          state_d = SHIFT;
        end else if (cnt_q == CW'(RDY_TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = GAP;
        end
`else
        if (cnt_q == CW'(CS_SETUP - 1))
          state_d = SHIFT;
`endif
      end
      SHIFT: begin
        if (div_end && sclk_q && bit_q == 4'd15)
          state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          hold_end = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (div_end)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cycle counter: restarts on every state change and SCLK half-period.
  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_d != state_q ||
                 (state_q == SHIFT && div_end)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Grant latch, SPI shift datapath and result registers.
  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      run_q    <= 1'b0;
      ptr_q    <= 2'd0;
      ch_q     <= 2'd0;
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      done_q <= '0;
      if (start) begin
        tx_q   <= {hdr[{pick, 3'b000} +: 8],
                   wdata[{pick, 3'b000} +: 8]};
        ch_q   <= pick;
        ptr_q  <= pick + 2'd1;
        rx_q   <= '0;
        bit_q  <= '0;
        sclk_q <= 1'b0;
      end
      if (state_q == SHIFT && div_end) begin
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[14:0], miso_s};
        end else begin
          sclk_q <= 1'b0;
          tx_q   <= {tx_q[14:0], 1'b0};
          bit_q  <= bit_q + 4'd1;
        end
      end
      if (hold_end) begin
        done_q   <= 4'(1) << ch_q;
        status_q <= rx_q[15:8];
        rdata_q  <= rx_q[7:0];
        err_q    <= 1'b0;
      end
      if (tmo) begin
        done_q   <= 4'(1) << ch_q;
        status_q <= 8'hFF;
        rdata_q  <= 8'hFF;
        err_q    <= 1'b1;
      end
    end
  end

  // Pin decode: only the active channel leaves its idle levels.
  always_comb begin
    gnt  = '0;
    CS_n = 4'hF;
    SCLK = '0;
    MOSI = '0;
    if (start)
      gnt[pick] = 1'b1;
    if (state_q == CS_WAIT || state_q == SHIFT || state_q == HOLD)
      CS_n[ch_q] = 1'b0;
    if (state_q == SHIFT) begin
      SCLK[ch_q] = sclk_q;
      MOSI[ch_q] = tx_q[15];
    end
  end

  assign done   = done_q;
  assign rdata  = rdata_q;
  assign status = status_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cc1200_spi_sched.sv
// tb_cc1200_spi_sched: directed bench for cc1200_spi_sched.
// Models each radio as a 16-bit reply word shifted out per SCLK rise.
module tb_cc1200_spi_sched;

  localparam int CD  = 4;
  localparam int CSU = 8;
  localparam int CSH = 4;
  localparam int RTO = 1024;
`ifdef CC1200_RDY_WAIT_EN
  localparam int RISE1 = 1 + 2 + CD;
  localparam int SPACE = 1 + 2 + 32 * CD + CSH + CD;
`else
  localparam int RISE1 = 1 + CSU + CD;
  localparam int SPACE = 1 + CSU + 32 * CD + CSH + CD;
`endif

  logic        sysclk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] hdr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt, done, SCLK, CS_n, MOSI, MISO;
  logic [7:0]  rdata, status;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] reply [4] = '{default: 16'h0000};
  logic [3:0]  force_hi = '0;

  int          rcnt [4] = '{default: 0};
  int          nrise [4] = '{default: 0};
  int          lowcyc [4] = '{default: 0};
  int          ndone [4] = '{default: 0};
  logic [15:0] mcap [4] = '{default: 16'h0};
  logic [3:0]  sprev = '0;
  logic [3:0]  csprev = 4'hF;
  int          t_gnt = 0, t_cs = 0, t_rise1 = 0;
  int          t_fall = 0, t_done = 0;

  cc1200_spi_sched #(
    .CLK_DIV(CD), .CS_SETUP(CSU),
    .CS_HOLD(CSH), .RDY_TIMEOUT(RTO)
  ) dut (
    .sysclk(sysclk), .rstn(rstn),
    .req(req), .hdr(hdr), .wdata(wdata),
    .gnt(gnt), .done(done),
    .rdata(rdata), .status(status), .err(err),
    .SCLK(SCLK), .CS_n(CS_n), .MOSI(MOSI),
    .MISO(MISO)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Radio model: next reply bit after each observed SCLK rise.
  always_comb begin
    MISO = '1;
    for (int i = 0; i < 4; i++) begin
      if (!force_hi[i] && rcnt[i] < 16)
        MISO[i] = reply[i][15 - rcnt[i]];
    end
  end

  // Pin monitor, sampled mid-cycle.
  always @(negedge sysclk) begin
    for (int i = 0; i < 4; i++) begin
      if (!CS_n[i]) lowcyc[i] <= lowcyc[i] + 1;
      if (!CS_n[i] && csprev[i]) begin
        rcnt[i] <= 0;
        t_cs    <= cyc;
      end
      if (SCLK[i] && !sprev[i]) begin
        if (rcnt[i] == 0) t_rise1 <= cyc;
        mcap[i]  <= {mcap[i][14:0], MOSI[i]};
        rcnt[i]  <= rcnt[i] + 1;
        nrise[i] <= nrise[i] + 1;
      end
      if (!SCLK[i] && sprev[i]) t_fall <= cyc;
      if (done[i]) begin
        ndone[i] <= ndone[i] + 1;
        t_done   <= cyc;
      end
    end
    if (gnt != 0) t_gnt <= cyc;
    sprev  <= SCLK;
    csprev <= CS_n;
  end

  task automatic wait_sig(input int which, input int bound,
                          output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge sysclk);
      if ((which == 0 && gnt != 0) ||
          (which == 1 && done != 0)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic int ch_of(input logic [3:0] v);
    ch_of = -1;
    for (int i = 0; i < 4; i++)
      if (v == (4'(1) << i)) ch_of = i;
  endfunction

  task automatic do_reset();
    @(posedge sysclk); #1 rstn = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    checks++;
    if ({gnt, done, err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_pulse: got gnt=%b done=%b err=%b want 0",
               gnt, done, err);
    end
    checks++;
    if ({CS_n, SCLK, MOSI} !== 12'hF00) begin
      errors++;
      $display("FAIL reset_pins: got cs=%b sclk=%b mosi=%b want 1111/0/0",
               CS_n, SCLK, MOSI);
    end
    checks++;
    if ({status, rdata} !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 00/00", status, rdata);
    end
    @(posedge sysclk); #1 rstn = 1'b1;
  endtask

  task automatic test_write();
    bit ok;
    int base, l0, l1, l3;
    reply[2] = 16'h0F00;
    hdr = 32'h000A_0000;
    wdata = 32'h005C_0000;
    base = nrise[2];
    l0 = lowcyc[0]; l1 = lowcyc[1]; l3 = lowcyc[3];
    @(posedge sysclk); #1 req = 4'b0100;
    wait_sig(0, 20, ok);
    checks++;
    if (!ok || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL wr_gnt: got %b want 0100", gnt);
    end
    @(posedge sysclk); #1 req = '0;
    wait_sig(1, 400, ok);
    checks++;
    if (!ok || done !== 4'b0100) begin
      errors++;
      $display("FAIL wr_done: got %b want 0100", done);
    end
    checks++;
    if (status !== 8'h0F || rdata !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL wr_result: got st=%h rd=%h err=%b want 0f/00/0",
               status, rdata, err);
    end
    @(negedge sysclk);
    checks++;
    if (mcap[2] !== 16'h0A5C || nrise[2] - base != 16) begin
      errors++;
      $display("FAIL wr_mosi: got %h rises=%0d want 0a5c rises=16",
               mcap[2], nrise[2] - base);
    end
    checks++;
    if (t_cs - t_gnt != 1 || t_rise1 - t_gnt != RISE1) begin
      errors++;
      $display("FAIL wr_timing: got cs=%0d rise=%0d want 1 %0d",
               t_cs - t_gnt, t_rise1 - t_gnt, RISE1);
    end
    checks++;
    if (t_done - t_fall != CSH) begin
      errors++;
      $display("FAIL wr_hold: got %0d want %0d", t_done - t_fall, CSH);
    end
    checks++;
    if (lowcyc[0] != l0 || lowcyc[1] != l1 || lowcyc[3] != l3) begin
      errors++;
      $display("FAIL wr_others: got cs-low cycles %0d %0d %0d want 0",
               lowcyc[0] - l0, lowcyc[1] - l1, lowcyc[3] - l3);
    end
  endtask

  task automatic test_read();
    bit ok;
    reply[0] = 16'h00A7;
    hdr = 32'h0000_008F;
    wdata = 32'h0;
    @(posedge sysclk); #1 req = 4'b0001;
    wait_sig(0, 20, ok);
    checks++;
    if (!ok || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rd_gnt: got %b want 0001", gnt);
    end
    @(posedge sysclk); #1 req = '0;
    wait_sig(1, 400, ok);
    checks++;
    if (!ok || done !== 4'b0001 || rdata !== 8'hA7 ||
        status !== 8'h00) begin
      errors++;
      $display("FAIL rd_result: got done=%b st=%h rd=%h want 0001/00/a7",
               done, status, rdata);
    end
    @(negedge sysclk);
    checks++;
    if (t_fall - t_rise1 + CD != 32 * CD || mcap[0] !== 16'h8F00) begin
      errors++;
      $display("FAIL rd_shift: got len=%0d mosi=%h want %0d 8f00",
               t_fall - t_rise1 + CD, mcap[0], 32 * CD);
    end
    repeat (10) @(negedge sysclk);
    checks++;
    if (rdata !== 8'hA7 || done !== 4'b0) begin
      errors++;
      $display("FAIL rd_hold: got rd=%h done=%b want a7/0000", rdata, done);
    end
  endtask

  task automatic test_rr(input bit drop);
    bit ok;
    int n;
    int got;
    int tprev;
    int exp_seq [7];
    bit dropped;
    if (drop) begin
      exp_seq = '{0, 1, 2, 3, 0, 2, 3};
      n = 7;
    end else begin
      exp_seq = '{0, 1, 2, 3, 0, 0, 0};
      n = 5;
    end
    reply = '{default: 16'h0000};
    dropped = 1'b0;
    tprev = 0;
    do_reset();
    req = 4'hF;
    for (int k = 0; k < n; k++) begin
      wait_sig(0, 400, ok);
      got = ch_of(gnt);
      checks++;
      if (!ok || got != exp_seq[k]) begin
        errors++;
        $display("FAIL rr%0d_gnt%0d: got ch %0d want ch %0d",
                 drop, k, got, exp_seq[k]);
      end
      if (k == 1) begin
        checks++;
        if (cyc - tprev != SPACE) begin
          errors++;
          $display("FAIL rr%0d_space: got %0d want %0d",
                   drop, cyc - tprev, SPACE);
        end
      end
      tprev = cyc;
      @(posedge sysclk); #1;
      if (drop && got == 1 && !dropped) begin
        req[1] = 1'b0;
        dropped = 1'b1;
      end
    end
    req = '0;
    wait_sig(1, 400, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base, nd;
    reply[1] = 16'h0000;
    hdr = 32'h0000_3C00;
    @(posedge sysclk); #1 req = 4'b0010;
    wait_sig(0, 400, ok);
    @(posedge sysclk); #1 req = '0;
    base = nrise[1];
    nd = ndone[1];
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge sysclk);
      if (nrise[1] - base >= 7) ok = 1'b1;
    end
    checks++;
    if (!ok || SCLK[1] !== 1'b1) begin
      errors++;
      $display("FAIL rm_reach: got rises=%0d sclk=%b want 7/1",
               nrise[1] - base, SCLK[1]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (CS_n !== 4'hF || SCLK !== 4'h0 || MOSI !== 4'h0) begin
      errors++;
      $display("FAIL rm_pins: got cs=%b sclk=%b mosi=%b want 1111/0/0",
               CS_n, SCLK, MOSI);
    end
    repeat (2) @(posedge sysclk);
    #1 rstn = 1'b1;
    req = 4'b0011;
    wait_sig(0, 20, ok);
    checks++;
    if (!ok || gnt !== 4'b0001 || ndone[1] != nd) begin
      errors++;
      $display("FAIL rm_prio: got gnt=%b dones=%0d want 0001/0",
               gnt, ndone[1] - nd);
    end
    @(posedge sysclk); #1 req = 4'b0010;
    wait_sig(0, 400, ok);
    checks++;
    if (!ok || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rm_next: got %b want 0010", gnt);
    end
    @(posedge sysclk); #1 req = '0;
    wait_sig(1, 400, ok);
    checks++;
    if (!ok || done !== 4'b0010 || status !== 8'h00) begin
      errors++;
      $display("FAIL rm_done: got %b st=%h want 0010/00", done, status);
    end
  endtask

`ifdef CC1200_RDY_WAIT_EN
  task automatic test_timeout();
    bit ok;
    int base;
    force_hi = 4'b1000;
    hdr = 32'h8100_0000;
    base = nrise[3];
    @(posedge sysclk); #1 req = 4'b1000;
    wait_sig(0, 400, ok);
    checks++;
    if (!ok || gnt !== 4'b1000) begin
      errors++;
      $display("FAIL to_gnt: got %b want 1000", gnt);
    end
    @(posedge sysclk); #1 req = '0;
    wait_sig(1, RTO + 50, ok);
    checks++;
    if (!ok || done !== 4'b1000 || err !== 1'b1 ||
        status !== 8'hFF || rdata !== 8'hFF) begin
      errors++;
      $display("FAIL to_result: got %b err=%b %h/%h want 1000/1/ff/ff",
               done, err, status, rdata);
    end
    @(negedge sysclk);
    checks++;
    if (nrise[3] != base || t_done - t_gnt != RTO + 1) begin
      errors++;
      $display("FAIL to_timing: got rises=%0d len=%0d want 0 %0d",
               nrise[3] - base, t_done - t_gnt, RTO + 1);
    end
    force_hi = '0;
    reply[0] = 16'h0055;
    @(posedge sysclk); #1 req = 4'b0001;
    wait_sig(0, 40, ok);
    @(posedge sysclk); #1 req = '0;
    wait_sig(1, 400, ok);
    checks++;
    if (!ok || done !== 4'b0001 || err !== 1'b0 || rdata !== 8'h55) begin
      errors++;
      $display("FAIL to_after: got %b err=%b rd=%h want 0001/0/55",
               done, err, rdata);
    end
  endtask
`else
  task automatic test_setup();
    bit ok;
    force_hi = 4'b1000;
    hdr = 32'hC300_0000;
    wdata = 32'h3C00_0000;
    @(posedge sysclk); #1 req = 4'b1000;
    wait_sig(0, 400, ok);
    @(posedge sysclk); #1 req = '0;
    wait_sig(1, 400, ok);
    checks++;
    if (!ok || done !== 4'b1000 || err !== 1'b0 ||
        status !== 8'hFF || rdata !== 8'hFF) begin
      errors++;
      $display("FAIL su_result: got %b err=%b %h/%h want 1000/0/ff/ff",
               done, err, status, rdata);
    end
    @(negedge sysclk);
    checks++;
    if (t_rise1 - t_cs != CSU + CD || mcap[3] !== 16'hC33C) begin
      errors++;
      $display("FAIL su_setup: got %0d mosi=%h want %0d c33c",
               t_rise1 - t_cs, mcap[3], CSU + CD);
    end
    force_hi = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rr(1'b0);
    test_rr(1'b1);
    test_reset_mid();
`ifdef CC1200_RDY_WAIT_EN
    test_timeout();
`else
    test_setup();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
